// File: rtl/ctrl_pkg.sv
// Shared opcode constants, phase enum and control-word layout for seq_controller.
package ctrl_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } run_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic halt;
    logic inc_pc;
    logic ld_ac;
    logic ld_pc;
    logic wr;
    logic data_e;
  } ctrl_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/seq_controller_if.sv
// Opcode/flag inputs and datapath control outputs of seq_controller.
interface seq_controller_if #(
  parameter int OPC_W = 3
);
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             go;
  logic             mem_ready;

  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             halt;
  logic             inc_pc;
  logic             ld_ac;
  logic             ld_pc;
  logic             wr;
  logic             data_e;
  logic [2:0]       phase;
  logic             illegal;

  // master: the controller; slave: the datapath side feeding opcode/flags.
  modport master (
    input  opcode, zero, go, mem_ready,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase, illegal
  );

  modport slave (
    output opcode, zero, go, mem_ready,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase, illegal
  );
endinterface

// File: rtl/phase_gen.sv
// 3-bit phase counter: clear wins over hold, otherwise advances and wraps 7->0.
module phase_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold_i,
  input  logic       clr_i,
  output logic [2:0] phase_o
);

  logic [2:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + 3'd1;
    if (clr_i)       phase_d = 3'd0;
    else if (hold_i) phase_d = phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 3'd0;
    else     phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/seq_controller.sv
// 8-phase instruction sequencer: opcode decode, Moore control table and HALTED state.
// Optional memory-wait stalls are built when CTRL_WAIT_EN is defined.
module seq_controller
  import ctrl_pkg::*;
#(
  parameter int OPC_W       = 3,
  parameter int HALT_RESUME = 1
) (
  input logic              clk,
  input logic              rst,
  seq_controller_if.master bus
);

  logic [OPC_W-1:0] opc;
  logic [2:0]       op3;
  logic [2:0]       phase;
  phase_e           ph;
  logic             rsv;
  logic             dec_hlt, dec_skz, dec_alu, dec_sto, dec_jmp;
  logic             hold, clr, stall, enter_halt, resume;
  run_e             state_q;
  ctrl_t            base, ctrl;

  assign opc = bus.opcode;
  assign op3 = opc[2:0];
  // Any bit above the low three marks a reserved opcode; always 0 when OPC_W=3.
  assign rsv = (opc >> 3) != '0;

  assign dec_hlt = !rsv && (op3 == HLT);
  assign dec_skz = !rsv && (op3 == SKZ);
  assign dec_alu = !rsv && is_alu(op3);
  assign dec_sto = !rsv && (op3 == STO);
  assign dec_jmp = !rsv && (op3 == JMP);

  assign ph = phase_e'(phase);

  always_comb begin
    base = '0;
    case (ph)
      INST_ADDR:  base.sel = 1'b1;
      INST_FETCH: begin
        base.sel = 1'b1;
        base.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        base.sel   = 1'b1;
        base.rd    = 1'b1;
        base.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        base.inc_pc = 1'b1;
        base.halt   = dec_hlt;
      end
      OP_FETCH:   base.rd = dec_alu;
      ALU_OP: begin
        base.rd     = dec_alu;
        base.inc_pc = dec_skz & bus.zero;
        base.ld_pc  = dec_jmp;
        base.data_e = dec_sto;
      end
      STORE: begin
        base.rd     = dec_alu;
        base.ld_ac  = dec_alu;
        base.ld_pc  = dec_jmp;
        base.wr     = dec_sto;
        base.data_e = dec_sto;
      end
      default: base = '0;
    endcase
  end

`ifdef CTRL_WAIT_EN
  logic mem_wait;
  assign mem_wait = ((ph inside {INST_FETCH, INST_LOAD, OP_FETCH, ALU_OP}) && base.rd) ||
                    ((ph == STORE) && base.wr);
  assign stall    = (state_q == RUN) && mem_wait && !bus.mem_ready;
`else
  assign stall = 1'b0;
`endif

  assign enter_halt = (state_q == RUN) && (ph == OP_ADDR) && dec_hlt;
  assign resume     = (state_q == HALTED) && (HALT_RESUME != 0) && bus.go;
  // Counter freezes at OP_ADDR on halt entry and stays there until resume clears it.
  assign hold       = enter_halt || ((state_q == HALTED) && !resume) || stall;
  assign clr        = resume;

  phase_gen u_phase_gen (
    .clk    (clk),
    .rst    (rst),
    .hold_i (hold),
    .clr_i  (clr),
    .phase_o(phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (enter_halt) state_q <= HALTED;
        HALTED:  if (resume)     state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Reset forces the INST_ADDR pattern immediately, independent of opcode and state.
  always_comb begin
    ctrl = base;
    if (rst) begin
      ctrl     = '0;
      ctrl.sel = 1'b1;
    end else if (state_q == HALTED) begin
      ctrl      = '0;
      ctrl.halt = 1'b1;
    end
  end

  assign bus.sel     = ctrl.sel;
  assign bus.rd      = ctrl.rd;
  assign bus.ld_ir   = ctrl.ld_ir;
  assign bus.halt    = ctrl.halt;
  assign bus.inc_pc  = ctrl.inc_pc;
  assign bus.ld_ac   = ctrl.ld_ac;
  assign bus.ld_pc   = ctrl.ld_pc;
  assign bus.wr      = ctrl.wr;
  assign bus.data_e  = ctrl.data_e;
  assign bus.phase   = rst ? 3'd0 : phase;
  assign bus.illegal = !rst && (state_q == RUN) && rsv && phase[2];

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter OPC_W, default 3, opcode width in bits; legal range 3..6.
REQ-002 Parameter HALT_RESUME, default 1; 1 means the go input releases HALTED, 0 means only rst releases HALTED.
REQ-003 clk  input  1  rising-edge clock, the block's only clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 opcode  input  OPC_W  instruction opcode, sampled every cycle.
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 go  input  1  resume request, used while HALTED.
REQ-008 mem_ready  input  1  memory handshake; used only when CTRL_WAIT_EN is defined.
REQ-009 sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  output  1 each  datapath controls.
REQ-010 phase  output  3  current phase, 0..7.
REQ-011 illegal  output  1  reserved opcode decoded; valid in phases 4..7.

Function
REQ-012 Decode: 0=HLT, 1=SKZ, 2..5=ALU, 6=STO, 7=JMP; any opcode >=8 (OPC_W>3) is RSV.
REQ-013 An internal counter sequences phases 0..7; it advances by 1 per cycle unless stalled or HALTED, and wraps 7->0.
REQ-014 Outputs are Moore-style from phase and decode; every unlisted output is 0:
- 0 INST_ADDR: sel.
- 1 INST_FETCH: sel, rd.
- 2 INST_LOAD and 3 IDLE: sel, rd, ld_ir.
- 4 OP_ADDR: inc_pc; halt=HLT.
- 5 OP_FETCH: rd=ALU.
- 6 ALU_OP: rd=ALU; inc_pc=SKZ&zero; ld_pc=JMP; data_e=STO.
- 7 STORE: rd=ALU; ld_ac=ALU; ld_pc=JMP; wr=STO; data_e=STO.
REQ-015 RSV behaves as a NOP: in phases 4..7 only the phase-4 inc_pc is asserted, and illegal=1.
REQ-016 In phase 4 with HLT decoded, the next state is HALTED.
- While HALTED: phase holds at 4, halt=1, all other outputs are 0.
- inc_pc is asserted only on the phase-4 entry cycle.
REQ-017 Leaving HALTED (HALT_RESUME=1): go=1 gives phase 0 on the next cycle. With HALT_RESUME=0, go is ignored.
REQ-018 go outside HALTED has no effect.
REQ-019 rst has priority over go, mem_ready and every phase transition.

Reset
REQ-020 Under rst=1 at a clock edge:
- phase becomes 0 and HALTED clears.
- On the cycle after, outputs are sel=1, all other controls 0, illegal=0.
REQ-021 While rst is high, outputs are held at the INST_ADDR pattern combinationally, whatever the opcode.
REQ-022 Reset mid-instruction, including during a stall or HALTED, abandons the instruction; no wr or ld_pc is issued afterwards.

Configuration
REQ-023 Macro CTRL_WAIT_EN.
REQ-024 With CTRL_WAIT_EN defined:
- In phases 1, 2, 5 and 6 with rd=1, or phase 7 with wr=1, the phase holds while mem_ready=0.
- All outputs stay stable during the stall.
- The phase advances on the first cycle mem_ready=1.
REQ-025 Without CTRL_WAIT_EN: mem_ready is unconnected internally, and each instruction takes exactly 8 cycles (HLT excepted).

Structure
REQ-026 Shared package ctrl_pkg holds the opcode constants (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) and the phase enum (INST_ADDR..STORE).
REQ-027 Sub-module phase_gen holds the 3-bit phase counter with hold and clear inputs; seq_controller holds the decode, output table and HALTED register.

Verification
REQ-028 Reset release, opcode=2, no stalls -> phase 0..7 over 8 cycles; ld_ac=1 only in phase 7; rd=1 in phases 1,2,3,5,6,7.
REQ-029 opcode=1, zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with zero=0 -> inc_pc=1 in phase 4 only.
REQ-030 opcode=0 -> halt=1 from phase 4 and phase frozen at 4 for 20 cycles; go pulse -> phase 0 next cycle. With HALT_RESUME=0 the go pulse is ignored.
REQ-031 CTRL_WAIT_EN defined, opcode=6, mem_ready=0 for 3 cycles in phase 7 -> wr=1 and data_e=1 held 4 cycles, then phase 0.
REQ-032 OPC_W=4, opcode=9 -> illegal=1 in phases 4..7; ld_ac, ld_pc, wr all stay 0.
REQ-033 rst asserted in phase 6 with opcode=7 -> ld_pc never asserts; phase 0 with sel=1 on the next cycle.
